sprdma: RTL

Sprite (OAM) DMA controller for the PPU register block. A CPU write to $4014 halts the CPU. The block then takes the CPU memory bus and copies the 256-byte page `{page, 8'h00}`–`{page, 8'hFF}` into sprite RAM. It does this through 256 ordinary writes to $2004, so the PPU register block sees normal OAMDATA writes and no extra port is needed. The block sits between the CPU and the memory controller, and its `active_out` drives the CPU ready/halt input.

---
 rtl/sprdma_pkg.sv | 15 +
 rtl/sprdma.sv | 100 ++++++++++
 2 files changed

// File: rtl/sprdma_pkg.sv
// Shared PPU/CPU definitions used by the sprite DMA block.
// Holds the OAM register addresses and the sprite DMA state encoding.
// Carries no logic of its own.
package sprdma_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_ACTIVE   = 2'd1,
    S_COOLDOWN = 2'd2
  } sprdma_state;

endpackage

// File: rtl/sprdma.sv
// Sprite (OAM) DMA: a $4014 write copies page {page,00..FF} to $2004 as 256 read/write beat pairs.
// Latency: the transfer starts on the first CPU read cycle after the trigger and then lasts 512 cycles.
// Flow control: no backpressure; active_out halts the CPU and all outputs are decoded from registered state.
// Ports: clk_in/rst_in (sync, active-high); cpumc_a_in/cpumc_din_in/cpu_r_nw_in carry the CPU bus;
//        cpumc_dout_in carries memory read data; active_out/cpumc_a_out/cpumc_d_out/cpumc_r_nw_out drive the DMA bus.
module sprdma
  import sprdma_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpumc_a_in,
  input  logic [7:0]  cpumc_din_in,
  input  logic [7:0]  cpumc_dout_in,
  input  logic        cpu_r_nw_in,
  output logic        active_out,
  output logic [15:0] cpumc_a_out,
  output logic [7:0]  cpumc_d_out,
  output logic        cpumc_r_nw_out
);

  sprdma_state state, state_nxt;
  logic [7:0]  page,  page_nxt;
  logic [7:0]  cnt,   cnt_nxt;
  logic        phase, phase_nxt;   // 0 = read beat, 1 = write beat
  logic [7:0]  data,  data_nxt;

  logic oamdma_wr;
  assign oamdma_wr = (cpumc_a_in == ADDR_OAMDMA) && !cpu_r_nw_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_READY;
      page  <= 8'h00;
      cnt   <= 8'h00;
      phase <= 1'b0;
      data  <= 8'h00;
    end else begin
      state <= state_nxt;
      page  <= page_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      data  <= data_nxt;
    end
  end

  // Next-state logic. CPU bus inputs are only consulted outside S_ACTIVE,
  // so a stray $4014 write during a transfer cannot retrigger it.
  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    data_nxt  = data;
    case (state)
      S_READY: begin
        if (oamdma_wr) begin
          page_nxt  = cpumc_din_in;
          cnt_nxt   = 8'h00;
          phase_nxt = 1'b0;
          state_nxt = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        // The CPU may still be finishing its write cycles; take the bus on the first read.
        if (oamdma_wr) page_nxt = cpumc_din_in;
        if (cpu_r_nw_in) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!phase) begin
          data_nxt  = cpumc_dout_in;
          phase_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + 8'd1;
          phase_nxt = 1'b0;
          if (cnt == 8'hFF) state_nxt = S_READY;
        end
      end
      default: state_nxt = S_READY;
    endcase
  end

  // Outputs depend only on registered state.
  always_comb begin
    active_out     = 1'b0;
    cpumc_a_out    = 16'h0000;
    cpumc_d_out    = 8'h00;
    cpumc_r_nw_out = 1'b1;
    if (state == S_ACTIVE) begin
      active_out = 1'b1;
      if (!phase) begin
        cpumc_a_out = {page, cnt};
      end else begin
        cpumc_a_out    = ADDR_OAMDATA;
        cpumc_d_out    = data;
        cpumc_r_nw_out = 1'b0;
      end
    end
  end

endmodule
